// File: rtl/race_bit_collector_pkg.sv
// Shared types and helpers for the race bit collector.
package race_collect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RACE,
    SAMPLE,
    STALL
  } rc_state_e;

  // Width of the shared CLEAR/RACE down-counter; it holds at most max(rst, race)-1.
  function automatic int unsigned run_cnt_w(input int unsigned rst_cycles,
                                            input int unsigned race_cycles);
    int unsigned m;
    m = (rst_cycles > race_cycles) ? rst_cycles : race_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/race_bit_collector_sync_ff.sv
// Single-bit flop-chain synchronizer, cleared by synchronous reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/race_bit_collector.sv
// Runs repeated clear/race/sample cycles on the race counter and packs the
// synchronized outcomes into words delivered over a one-deep valid/ready slot.
module race_bit_collector
  import race_collect_pkg::*;
#(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned RACE_CYCLES = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic                         race_val_i,
  output logic                         race_rst_n_o,
  output logic [WORD_W-1:0]            word_o,
  output logic [$clog2(WORD_W+1)-1:0]  ones_o,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic                         busy_o,
  output logic                         stall_o
);

  localparam int unsigned OW = $clog2(WORD_W + 1);
  localparam int unsigned IW = $clog2(WORD_W);
  localparam int unsigned CW = run_cnt_w(RST_CYCLES, RACE_CYCLES);

  rc_state_e         state, state_n;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] shreg, load_word;
  logic [OW-1:0]     acc, load_ones;
  logic              sampled, last_bit, slot_free, do_shift, do_load;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (race_val_i),
    .q   (sampled)
  );

  assign last_bit  = (idx == IW'(WORD_W - 1));
  assign slot_free = !word_valid_o || word_ready_i;

  // In SAMPLE the finished word includes the incoming bit; in STALL it already sits in shreg/acc.
  always_comb begin
    state_n   = state;
    do_shift  = 1'b0;
    do_load   = 1'b0;
    load_word = shreg;
    load_ones = acc;
    case (state)
      IDLE:  if (enable_i) state_n = CLEAR;
      CLEAR: if (cnt == '0) state_n = RACE;
      RACE:  if (cnt == '0) state_n = SAMPLE;
      SAMPLE: begin
        do_shift  = 1'b1;
        load_word = {shreg[WORD_W-2:0], sampled};
        load_ones = acc + OW'(sampled);
        if (!last_bit) begin
          state_n = CLEAR;
        end else if (slot_free) begin
          do_load = 1'b1;
          state_n = enable_i ? CLEAR : IDLE;
        end else begin
          state_n = STALL;
        end
      end
      STALL: begin
        if (word_ready_i) begin
          do_load = 1'b1;
          state_n = enable_i ? CLEAR : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      acc          <= '0;
      word_o       <= '0;
      ones_o       <= '0;
      word_valid_o <= 1'b0;
      race_rst_n_o <= 1'b0;
    end else begin
      state        <= state_n;
      race_rst_n_o <= (state_n == RACE) || (state_n == SAMPLE);

      if (state_n == CLEAR && state != CLEAR)     cnt <= CW'(RST_CYCLES - 1);
      else if (state_n == RACE && state != RACE)  cnt <= CW'(RACE_CYCLES - 1);
      else if (cnt != '0)                         cnt <= cnt - CW'(1);

      if (do_shift) begin
        shreg <= load_word;
        acc   <= load_ones;
        if (!last_bit) idx <= idx + IW'(1);
      end

      if (do_load) begin
        word_o       <= load_word;
        ones_o       <= load_ones;
        word_valid_o <= 1'b1;
        idx          <= '0;
        acc          <= '0;
      end else if (word_ready_i) begin
        word_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o  = (state != IDLE);
  assign stall_o = (state == STALL);

endmodule

// File: doc/race_bit_collector.md
# race_bit_collector

Clocked consumer for the comparator race counter. It repeatedly resets the race counter, lets one race run for a fixed window, and samples the counter's asynchronous `binary_val` result through a synchronizer. It packs `WORD_W` decisions into a word and hands each word downstream over a valid/ready handshake, with one word of buffering so collection continues under backpressure.

## Interface
- `WORD_W`, 8: decision bits per output word (2..32)
- `RST_CYCLES`, 16: clk cycles the race counter is held in reset per race (≥1)
- `RACE_CYCLES`, 256: clk cycles a race is allowed to run before sampling (> `SYNC_STAGES`)
- `SYNC_STAGES`, 2: synchronizer depth for `race_val_i` (≥2)

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `enable_i`  in  1  start and continue collecting words
- `race_val_i`  in  1  race counter `binary_val` (asynchronous to `clk`); 1 = A won, 0 = B won or no winner
- `race_rst_n_o`  out  1  drives race counter `rst_n`; 0 = hold counter cleared
- `word_o`  out  `WORD_W`  collected word; first decision in MSB
- `ones_o`  out  `$clog2(WORD_W+1)`  popcount of `word_o`
- `word_valid_o`  out  1  `word_o`/`ones_o` valid
- `word_ready_i`  in  1  downstream accepts; transfer when valid && ready
- `busy_o`  out  1  FSM not in IDLE
- `stall_o`  out  1  FSM in STALL

## Operation
- Reset values: `race_rst_n_o`=0, `word_o`=0, `ones_o`=0, `word_valid_o`=0, `busy_o`=0, `stall_o`=0. FSM enters IDLE; bit index, shift register, run counters and synchronizer flops are all cleared.
- FSM states: IDLE, CLEAR, RACE, SAMPLE, STALL.
- IDLE: `race_rst_n_o`=0. If `enable_i`=1, go to CLEAR.
- CLEAR: `race_rst_n_o`=0 for exactly `RST_CYCLES` cycles, then go to RACE.
- RACE: `race_rst_n_o`=1 for exactly `RACE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE, one cycle, `race_rst_n_o`=1:
  - Shift the synchronized bit in: shreg <= {shreg[W-2:0], bit}.
  - Increment the ones accumulator if bit=1.
  - If bit index < `WORD_W`-1: increment the index and go to CLEAR.
  - Otherwise the word is complete.
- Word complete, output slot free (`word_valid_o`=0, or handshake this cycle):
  - Load `word_o` and `ones_o`; set `word_valid_o`=1.
  - Clear the index and accumulator.
  - Go to CLEAR if `enable_i`=1, else IDLE.
- Word complete, slot occupied: go to STALL. `race_rst_n_o`=0; hold the shift register.
- STALL: on handshake, load the output slot next edge, then go to CLEAR or IDLE per `enable_i`.
- `word_valid_o` clears on handshake unless a new word loads that same edge; in that case valid stays 1.
- `word_o`/`ones_o` hold stable while valid and not accepted.
- `enable_i` dropping mid-word: the current word is completed; the FSM returns to IDLE after it is delivered to the slot.
- `rst` mid-race: the FSM aborts and the partial word is discarded. `race_rst_n_o`=0 the next cycle.
- A race with no winner reads 0. This is indistinguishable from a B win by design.

## Timing
- `enable_i` sampled high in IDLE at edge 0: CLEAR begins at cycle 1.
- Per bit: `RST_CYCLES`+`RACE_CYCLES`+1 cycles (defaults: 273).
- First `word_valid_o` rises at cycle 1+`WORD_W`·(`RST_CYCLES`+`RACE_CYCLES`+1) (defaults: 2185).
- Unthrottled word period: `WORD_W`·273 = 2184 cycles.
- Sampled bit = `race_val_i` as of `SYNC_STAGES` cycles before the SAMPLE edge.
- The race therefore effectively runs `RACE_CYCLES`−`SYNC_STAGES` cycles.

## Structure
- Package `race_collect_pkg`: state enum `rc_state_e` (IDLE, CLEAR, RACE, SAMPLE, STALL) and the run-counter width function.
- Sub-module `sync_ff #(STAGES)`: single-bit flop-chain synchronizer, reset to 0 by `rst`.
- One shared down-counter serves CLEAR and RACE, reloaded on each state entry.

## Test plan
- Reset, then `race_val_i`=1 constant, `enable_i`=1, ready=1 → `word_o`=8'hFF, `ones_o`=8, valid at cycle 2185.
- Alternate `race_val_i` 1,0 per race, aligned to CLEAR → `word_o`=8'hAA, `ones_o`=4.
- Hold ready=0 through two words → first word stable; STALL entered at cycle 4369, `race_rst_n_o`=0. Raise ready → first word transfers; second word valid the next cycle.
- `rst` asserted during race 3 → all outputs at reset values next cycle; restart produces a full fresh word with no stale bits.
- `enable_i` dropped during bit 5 → word completes, `word_valid_o`=1, FSM goes to IDLE, `busy_o`=0, no further CLEAR.
- Check `race_rst_n_o` low for exactly 16 cycles and high for exactly 257 per bit.
